gate_response_checker: RTL and testbench
========================================

# gate_response_checker

Synthesizable response checker for two-input logic primitives: the observing end of the stimulus/response pair used to exercise gate-level blocks such as the primitive AND. It samples the stimulus pair (a, b) and the DUT output c, waits for the stimulus to settle, and compares c against the expected function. It accumulates check/error counts and a per-vector coverage mask, and raises done/pass once all four input combinations have been checked.

## Interface
- OP, 0: expected function; 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; other values behave as AND
- SETTLE, 2: sampled cycles (a, b) must hold stable before c is checked; range 0..15
- CNT_W, 8: width of check_count and error_count

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- enable  in  1  monitoring enable; low forces IDLE, counters hold
- clear  in  1  synchronous clear of counters, coverage and first-error capture
- a  in  1  observed stimulus bit a
- b  in  1  observed stimulus bit b
- c  in  1  observed DUT output
- check_count  out  CNT_W  checks performed, saturating
- error_count  out  CNT_W  failed checks, saturating
- coverage  out  4  bit {a,b} set once that vector has been checked
- mismatch  out  1  one-cycle pulse on a failing check
- first_err_valid  out  1  a failure has been captured since reset/clear
- first_err_vec  out  3  {a,b,c} of the first failing check
- done  out  1  high in DONE state
- pass  out  1  done and error_count == 0

## Operation
- Input stage: a, b, c are registered every edge into a_q, b_q, c_q. All decisions use the registered values.
- Stability tracking:
  - stab_cnt (4 bits) resets to 0 on any edge where {a_q,b_q} differs from its previous value.
  - Otherwise it increments, saturating at SETTLE.
  - run_checked is cleared on a change and set when a check fires.
- FSM states:
  - IDLE: entered on reset, or whenever enable is low. stab_cnt is held at 0 and no checks fire.
  - MONITOR: entered from IDLE on the edge with enable high. A check fires on an edge where stab_cnt == SETTLE and run_checked == 0.
  - DONE: entered on the edge after coverage reaches 4'hF. No further checks fire. Exits to IDLE when enable goes low, or to MONITOR when clear is asserted with enable high.
- Check actions:
  - expected = f_OP(a_q, b_q).
  - check_count increments (saturating).
  - coverage[{a_q,b_q}] is set.
  - If c_q != expected: error_count increments (saturating) and mismatch pulses high for one cycle. If first_err_valid is 0, {a_q,b_q,c_q} is captured and first_err_valid is set.
- clear:
  - Zeroes check_count, error_count, coverage, first_err_*, stab_cnt and run_checked.
  - Takes priority over a check in the same cycle (counters end at 0, mismatch stays low).
  - Next state is MONITOR if enable is high, else IDLE.
- Each stable run yields at most one check. A vector that is held for a long time is checked once.

## Timing
- Reset (async assert, sync-released by the system): all outputs 0, state IDLE, a_q/b_q/c_q = 0, stab_cnt = 0.
- Latency: when (a, b) change just before edge k, the check updates outputs at edge k+SETTLE+1, using c sampled at edge k+SETTLE.
- mismatch is registered, high for exactly the one cycle following the check edge.
- Glitches: a run shorter than SETTLE+1 samples produces no check.
- Entering MONITOR: stab_cnt starts at 0, so the first check comes SETTLE+1 edges after enable rises, even with static inputs.
- Simultaneous events:
  - enable low and a check due in the same cycle: enable wins, no check.
  - Coverage completing and done: done asserts one edge after the final check.
- rst_n asserted mid-operation clears all state immediately, regardless of clk.

## Test plan
- AND (OP=0, SETTLE=2), enable=1. Drive ab=00 for 10 cycles, 01 for 20, 10 for 30, 11 for 40, with c = a&b → check_count=4, error_count=0, coverage=4'hF, mismatch never high, done=1, pass=1.
- Same sequence with c stuck at 0 → single mismatch pulse during the 11 run, error_count=1, first_err_vec=3'b110, first_err_valid=1, done=1, pass=0.
- Toggle ab every cycle for 6 cycles with SETTLE=2 → check_count stays 0. Then hold ab=01 → exactly one check, 3 edges after the last change.
- CNT_W=2, OP=1 (OR) with c inverted, 5 stable runs alternating 01/10 → error_count=3 (saturated), check_count=3, first_err_vec=3'b010.
- Assert clear on the same edge a check is due → check_count=0, coverage=0, mismatch stays 0. The next stable run checks normally.
- Assert rst_n low mid-run (after 2 checks) → all outputs 0 immediately, without a clk edge. After release with enable high, the first check occurs SETTLE+1 edges later.

Source files
------------

// File: rtl/gate_response_checker.sv
// Response checker for two-input logic primitives.
// Samples the stimulus pair (a, b) and the observed output c. Once the pair has
// been stable for SETTLE sampled cycles, c is compared against the selected
// function once for that stable run. The checker counts checks and errors,
// records which input vectors were covered, captures the first failing vector,
// and reports done/pass after all four vectors have been checked.
module gate_response_checker #(
    parameter int OP     = 0,  // 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, else AND
    parameter int SETTLE = 2,  // stable sampled cycles required before a check (0..15)
    parameter int CNT_W  = 8   // width of the check and error counters
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] error_count,
    output logic [3:0]       coverage,
    output logic             mismatch,
    output logic             first_err_valid,
    output logic [2:0]       first_err_vec,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MONITOR = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_a_q;
    logic             r_b_q;
    logic             r_c_q;
    logic [3:0]       r_stab_cnt;
    logic             r_run_checked;
    logic [CNT_W-1:0] r_check_count;
    logic [CNT_W-1:0] r_error_count;
    logic [3:0]       r_coverage;
    logic             r_mismatch;
    logic             r_first_err_valid;
    logic [2:0]       r_first_err_vec;

    logic             w_changed;
    logic             w_fire;
    logic             w_expected;
    logic             w_bad;

    // Expected output of the selected primitive.
    function automatic logic f_expected(input logic x, input logic y);
        case (OP)
            1:       return x | y;
            2:       return x ^ y;
            3:       return ~(x & y);
            4:       return ~(x | y);
            5:       return ~(x ^ y);
            default: return x & y;
        endcase
    endfunction

    // Increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The sampled pair is about to take a new value on this edge.
    assign w_changed  = ({a, b} != {r_a_q, r_b_q});
    assign w_expected = f_expected(r_a_q, r_b_q);
    // One check per stable run; enable and clear both suppress it.
    assign w_fire     = (r_state == S_MONITOR) && enable && !clear &&
                        (r_stab_cnt == SETTLE_C) && !r_run_checked;
    assign w_bad      = w_fire && (r_c_q != w_expected);

    // Input sampling stage: every decision is made on these registered copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q <= 1'b0;
            r_b_q <= 1'b0;
            r_c_q <= 1'b0;
        end else begin
            r_a_q <= a;
            r_b_q <= b;
            r_c_q <= c;
        end
    end

    // Stability counter and per-run "already checked" flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stab_cnt    <= 4'd0;
            r_run_checked <= 1'b0;
        end else if (clear || (r_state == S_IDLE) || w_changed) begin
            r_stab_cnt    <= 4'd0;
            r_run_checked <= 1'b0;
        end else begin
            if (r_stab_cnt != SETTLE_C) begin
                r_stab_cnt <= r_stab_cnt + 4'd1;
            end
            if (w_fire) begin
                r_run_checked <= 1'b1;
            end
        end
    end

    // Check results: counters, coverage, first-error capture and mismatch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_check_count     <= '0;
            r_error_count     <= '0;
            r_coverage        <= 4'd0;
            r_mismatch        <= 1'b0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= 3'd0;
        end else if (clear) begin
            r_check_count     <= '0;
            r_error_count     <= '0;
            r_coverage        <= 4'd0;
            r_mismatch        <= 1'b0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= 3'd0;
        end else begin
            r_mismatch <= w_bad;
            if (w_fire) begin
                r_check_count                <= f_sat_inc(r_check_count);
                r_coverage[{r_a_q, r_b_q}]   <= 1'b1;
                if (w_bad) begin
                    r_error_count <= f_sat_inc(r_error_count);
                    if (!r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_vec   <= {r_a_q, r_b_q, r_c_q};
                    end
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: enable low always returns to IDLE, clear restarts monitoring.
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = S_IDLE;
        end else if (clear) begin
            w_next_state = S_MONITOR;
        end else begin
            case (r_state)
                S_IDLE:    w_next_state = S_MONITOR;
                S_MONITOR: w_next_state = (r_coverage == 4'hF) ? S_DONE : S_MONITOR;
                S_DONE:    w_next_state = S_DONE;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    assign check_count     = r_check_count;
    assign error_count     = r_error_count;
    assign coverage        = r_coverage;
    assign mismatch        = r_mismatch;
    assign first_err_valid = r_first_err_valid;
    assign first_err_vec   = r_first_err_vec;
    assign done            = (r_state == S_DONE);
    assign pass            = (r_state == S_DONE) && (r_error_count == '0);

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: six instances (one per function, assorted
// SETTLE/CNT_W) compared every cycle against a window-based reference model,
// with directed scenarios pinned by literal expectations and a random phase.
module tb_gate_response_checker;

    localparam int NI = 6;

    function automatic int settle_of(input int g);
        case (g)
            2:       return 0;
            3:       return 3;
            4:       return 1;
            5:       return 5;
            default: return 2;
        endcase
    endfunction

    function automatic int cw_of(input int g);
        case (g)
            1:       return 2;
            3:       return 3;
            default: return 8;
        endcase
    endfunction

    // Function value from the number of ones on the inputs.
    function automatic logic f_model(input int op, input logic x, input logic y);
        int ones;
        ones = int'(x) + int'(y);
        case (op)
            1:       return ones > 0;
            2:       return ones == 1;
            3:       return ones != 2;
            4:       return ones == 0;
            5:       return ones != 1;
            default: return ones == 2;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c_in [NI];

    logic [7:0] d_chk  [NI];
    logic [7:0] d_err  [NI];
    logic [3:0] d_cov  [NI];
    logic       d_mis  [NI];
    logic       d_fev  [NI];
    logic [2:0] d_fvec [NI];
    logic       d_done [NI];
    logic       d_pass [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : G
        localparam int CW = cw_of(g);
        logic [CW-1:0] w_chk;
        logic [CW-1:0] w_err;
        gate_response_checker #(.OP(g), .SETTLE(settle_of(g)), .CNT_W(CW)) u_dut (
            .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
            .a(a), .b(b), .c(c_in[g]),
            .check_count(w_chk), .error_count(w_err), .coverage(d_cov[g]),
            .mismatch(d_mis[g]), .first_err_valid(d_fev[g]),
            .first_err_vec(d_fvec[g]), .done(d_done[g]), .pass(d_pass[g]));
        assign d_chk[g] = 8'(w_chk);
        assign d_err[g] = 8'(w_err);
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // A check fires when the sampled vector has sat in one window (started by a
    // change, a clear or an IDLE cycle) for exactly SETTLE+1 edges.
    int   n_edge = 0;
    int   m_chk [NI];
    int   m_err [NI];
    int   m_cov [NI];
    int   m_st  [NI];  // 0 idle, 1 monitoring, 2 done
    int   m_start [NI];
    logic m_mis [NI];
    logic m_fev [NI];
    logic [2:0] m_fvec [NI];
    logic m_aq [NI];
    logic m_bq [NI];
    logic m_cq [NI];

    task automatic m_reset_all();
        for (int g = 0; g < NI; g++) begin
            m_chk[g] = 0; m_err[g] = 0; m_cov[g] = 0; m_st[g] = 0;
            m_start[g] = n_edge; m_mis[g] = 1'b0; m_fev[g] = 1'b0;
            m_fvec[g] = 3'd0; m_aq[g] = 1'b0; m_bq[g] = 1'b0; m_cq[g] = 1'b0;
        end
    endtask

    task automatic m_step(input int g);
        int mx, cov_pre, st_pre;
        logic fire, e;
        mx = (1 << cw_of(g)) - 1;
        cov_pre = m_cov[g];
        st_pre = m_st[g];
        fire = (st_pre == 1) && enable && !clear && (n_edge - m_start[g] == settle_of(g) + 1);
        m_mis[g] = 1'b0;
        if (fire) begin
            e = f_model(g, m_aq[g], m_bq[g]);
            if (m_chk[g] < mx) m_chk[g]++;
            m_cov[g] = m_cov[g] | (1 << (2 * int'(m_aq[g]) + int'(m_bq[g])));
            if (m_cq[g] != e) begin
                if (m_err[g] < mx) m_err[g]++;
                m_mis[g] = 1'b1;
                if (!m_fev[g]) begin
                    m_fev[g] = 1'b1;
                    m_fvec[g] = {m_aq[g], m_bq[g], m_cq[g]};
                end
            end
        end
        if (clear) begin
            m_chk[g] = 0; m_err[g] = 0; m_cov[g] = 0; m_mis[g] = 1'b0;
            m_fev[g] = 1'b0; m_fvec[g] = 3'd0; m_start[g] = n_edge;
        end
        if (!enable) m_st[g] = 0;
        else if (clear) m_st[g] = 1;
        else if (st_pre == 0) m_st[g] = 1;
        else if (st_pre == 1 && cov_pre == 15) m_st[g] = 2;
        if (st_pre == 0) m_start[g] = n_edge;
        if ({a, b} != {m_aq[g], m_bq[g]}) m_start[g] = n_edge;
        m_aq[g] = a; m_bq[g] = b; m_cq[g] = c_in[g];
    endtask

    initial begin
        m_reset_all();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset_all();
            else begin
                n_edge++;
                for (int g = 0; g < NI; g++) m_step(g);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int mis_seen0 = 0;
    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                check($sformatf("g%0d check_count", g), int'(d_chk[g]), m_chk[g]);
                check($sformatf("g%0d error_count", g), int'(d_err[g]), m_err[g]);
                check($sformatf("g%0d coverage", g), int'(d_cov[g]), m_cov[g]);
                check($sformatf("g%0d mismatch", g), int'(d_mis[g]), int'(m_mis[g]));
                check($sformatf("g%0d first_err_valid", g), int'(d_fev[g]), int'(m_fev[g]));
                check($sformatf("g%0d first_err_vec", g), int'(d_fvec[g]), int'(m_fvec[g]));
                check($sformatf("g%0d done", g), int'(d_done[g]), int'(m_st[g] == 2));
                check($sformatf("g%0d pass", g), int'(d_pass[g]), int'(m_st[g] == 2 && m_err[g] == 0));
            end
            if (d_mis[0]) mis_seen0++;
        end
    end

    // ---------------- stimulus ----------------
    int cmode [NI];  // 0 correct, 1 stuck at 0, 2 inverted, 3 mostly correct

    task automatic drive(input logic [1:0] ab);
        logic e;
        a = ab[1];
        b = ab[0];
        for (int g = 0; g < NI; g++) begin
            e = f_model(g, ab[1], ab[0]);
            case (cmode[g])
                0:       c_in[g] = e;
                1:       c_in[g] = 1'b0;
                2:       c_in[g] = ~e;
                default: c_in[g] = ($urandom_range(0, 7) == 0) ? ~e : e;
            endcase
        end
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        repeat (n) begin
            @(negedge clk);
            drive(ab);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Edge index (1 = first edge after the call) at which dut0 check_count reaches target.
    task automatic wait_check(input int target, output int found);
        found = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (found == 0 && int'(d_chk[0]) == target) found = i;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int snap;
    int found;
    logic [1:0] r_ab;
    int r_len;

    initial begin
        for (int g = 0; g < NI; g++) begin
            c_in[g] = 1'b0;
            cmode[g] = 0;
        end
        #1;
        check("reset check_count", int'(d_chk[0]), 0);
        check("reset done", int'(d_done[0]), 0);
        check("reset first_err_valid", int'(d_fev[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;

        // AND with correct responses: all four vectors, no errors.
        snap = mis_seen0;
        hold(2'b00, 10); hold(2'b01, 20); hold(2'b10, 30); hold(2'b11, 40);
        #2;
        check("A check_count", int'(d_chk[0]), 4);
        check("A error_count", int'(d_err[0]), 0);
        check("A coverage", int'(d_cov[0]), 15);
        check("A mismatch pulses", mis_seen0 - snap, 0);
        check("A done", int'(d_done[0]), 1);
        check("A pass", int'(d_pass[0]), 1);
        check("A model check_count", m_chk[0], 4);

        // Same sequence with c stuck at 0.
        cmode[0] = 1;
        pulse_clear();
        snap = mis_seen0;
        hold(2'b00, 10); hold(2'b01, 20); hold(2'b10, 30); hold(2'b11, 40);
        #2;
        check("B mismatch pulses", mis_seen0 - snap, 1);
        check("B error_count", int'(d_err[0]), 1);
        check("B first_err_vec", int'(d_fvec[0]), 3'b110);
        check("B first_err_valid", int'(d_fev[0]), 1);
        check("B done", int'(d_done[0]), 1);
        check("B pass", int'(d_pass[0]), 0);
        cmode[0] = 0;

        // Glitching pair produces no check; a held vector is checked once, 3 edges on.
        pulse_clear();
        hold(2'b01, 1); hold(2'b10, 1); hold(2'b01, 1);
        hold(2'b10, 1); hold(2'b01, 1); hold(2'b10, 1);
        #2;
        check("C toggle check_count", int'(d_chk[0]), 0);
        @(negedge clk);
        drive(2'b01);
        wait_check(1, found);
        check("C latency edge", found, 4);
        hold(2'b01, 10);
        #2;
        check("C single check", int'(d_chk[0]), 1);

        // OR with inverted responses on the 2-bit-counter instance.
        cmode[1] = 2;
        pulse_clear();
        hold(2'b01, 5); hold(2'b10, 5); hold(2'b01, 5); hold(2'b10, 5); hold(2'b01, 5);
        #2;
        check("D error_count", int'(d_err[1]), 3);
        check("D check_count", int'(d_chk[1]), 3);
        check("D first_err_vec", int'(d_fvec[1]), 3'b010);
        check("D model error_count", m_err[1], 3);
        cmode[1] = 0;

        // Clear on the same edge a check is due.
        pulse_clear();
        snap = mis_seen0;
        @(negedge clk);
        drive(2'b11);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #2;
        check("E check_count after clear", int'(d_chk[0]), 0);
        check("E coverage after clear", int'(d_cov[0]), 0);
        hold(2'b11, 4);
        #2;
        check("E next run check_count", int'(d_chk[0]), 1);
        check("E next run coverage", int'(d_cov[0]), 8);
        check("E mismatch pulses", mis_seen0 - snap, 0);

        // Asynchronous reset after two checks, then restart latency.
        pulse_clear();
        hold(2'b00, 5); hold(2'b01, 5);
        #2;
        check("F checks before reset", int'(d_chk[0]), 2);
        rst_n = 1'b0;
        #1;
        check("F reset check_count", int'(d_chk[0]), 0);
        check("F reset coverage", int'(d_cov[0]), 0);
        check("F reset done", int'(d_done[0]), 0);
        check("F reset first_err_vec", int'(d_fvec[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_check(1, found);
        check("F restart latency edge", found, 4);

        // Random runs, glitches, enable drops, clears and one mid-run reset.
        for (int g = 0; g < NI; g++) cmode[g] = 3;
        for (int it = 0; it < 2500; it++) begin
            r_ab = 2'($urandom_range(0, 3));
            r_len = $urandom_range(1, 6);
            for (int j = 0; j < r_len; j++) begin
                @(negedge clk);
                enable = ($urandom_range(0, 29) != 0);
                clear = ($urandom_range(0, 49) == 0);
                drive(r_ab);
            end
            if (it == 1200) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        enable = 1'b1;
        clear = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
